// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: combinational decode of the incoming word into a
// 2-entry (main + skid) output buffer with a registered in_ready.
module decode_stage #(
    parameter int unsigned XLEN    = 32,
    parameter bit          EXT_ISA = 1'b1,
    parameter int unsigned CMD_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CMD_W-1:0] out_cmd,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_shamt,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_jaddr,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal
);

    localparam logic [CMD_W-1:0] CMD_LW      = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_SW      = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_J       = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_JAL     = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_BEQ     = CMD_W'(4);
    localparam logic [CMD_W-1:0] CMD_BNE     = CMD_W'(5);
    localparam logic [CMD_W-1:0] CMD_XORI    = CMD_W'(6);
    localparam logic [CMD_W-1:0] CMD_ADDI    = CMD_W'(7);
    localparam logic [CMD_W-1:0] CMD_JR      = CMD_W'(8);
    localparam logic [CMD_W-1:0] CMD_ADD     = CMD_W'(9);
    localparam logic [CMD_W-1:0] CMD_SUB     = CMD_W'(10);
    localparam logic [CMD_W-1:0] CMD_SLT     = CMD_W'(11);
    localparam logic [CMD_W-1:0] CMD_ANDI    = CMD_W'(12);
    localparam logic [CMD_W-1:0] CMD_ORI     = CMD_W'(13);
    localparam logic [CMD_W-1:0] CMD_LUI     = CMD_W'(14);
    localparam logic [CMD_W-1:0] CMD_AND     = CMD_W'(15);
    localparam logic [CMD_W-1:0] CMD_OR      = CMD_W'(16);
    localparam logic [CMD_W-1:0] CMD_NOR     = CMD_W'(17);
    localparam logic [CMD_W-1:0] CMD_SLL     = CMD_W'(18);
    localparam logic [CMD_W-1:0] CMD_SRL     = CMD_W'(19);
    localparam logic [CMD_W-1:0] CMD_ILLEGAL = CMD_W'(31);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2a;

    typedef struct packed {
        logic [CMD_W-1:0] cmd;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       rd;
        logic [4:0]       shamt;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  jaddr;
        logic [XLEN-1:0]  pc;
        logic             illegal;
    } entry_t;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } state_e;

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [CMD_W-1:0] dec_cmd;
    logic [XLEN-1:0]  dec_imm;
    entry_t           dec;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept;

    assign opcode = in_instr[31:26];
    assign funct  = in_instr[5:0];

    // Extended encodings fall through to ILLEGAL when EXT_ISA is 0.
    always_comb begin
        dec_cmd = CMD_ILLEGAL;
        case (opcode)
            OP_LW:   dec_cmd = CMD_LW;
            OP_SW:   dec_cmd = CMD_SW;
            OP_J:    dec_cmd = CMD_J;
            OP_JAL:  dec_cmd = CMD_JAL;
            OP_BEQ:  dec_cmd = CMD_BEQ;
            OP_BNE:  dec_cmd = CMD_BNE;
            OP_XORI: dec_cmd = CMD_XORI;
            OP_ADDI: dec_cmd = CMD_ADDI;
            OP_ANDI: if (EXT_ISA) dec_cmd = CMD_ANDI;
            OP_ORI:  if (EXT_ISA) dec_cmd = CMD_ORI;
            OP_LUI:  if (EXT_ISA) dec_cmd = CMD_LUI;
            OP_RTYPE: begin
                case (funct)
                    FN_JR:  dec_cmd = CMD_JR;
                    FN_ADD: dec_cmd = CMD_ADD;
                    FN_SUB: dec_cmd = CMD_SUB;
                    FN_SLT: dec_cmd = CMD_SLT;
                    FN_AND: if (EXT_ISA) dec_cmd = CMD_AND;
                    FN_OR:  if (EXT_ISA) dec_cmd = CMD_OR;
                    FN_NOR: if (EXT_ISA) dec_cmd = CMD_NOR;
                    FN_SLL: if (EXT_ISA) dec_cmd = CMD_SLL;
                    FN_SRL: if (EXT_ISA) dec_cmd = CMD_SRL;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        dec_imm = XLEN'($signed(in_instr[15:0]));
        if (dec_cmd == CMD_XORI || dec_cmd == CMD_ANDI || dec_cmd == CMD_ORI) begin
            dec_imm = XLEN'(in_instr[15:0]);
        end else if (dec_cmd == CMD_LUI) begin
            dec_imm = XLEN'({in_instr[15:0], 16'h0000});
        end
    end

    always_comb begin
        dec.cmd     = dec_cmd;
        dec.rs      = in_instr[25:21];
        dec.rt      = in_instr[20:16];
        dec.rd      = in_instr[15:11];
        dec.shamt   = in_instr[10:6];
        dec.imm     = dec_imm;
        dec.jaddr   = {in_pc[XLEN-1:28], in_instr[25:0], 2'b00};
        dec.pc      = in_pc;
        dec.illegal = (dec_cmd == CMD_ILLEGAL);
    end

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_d  = dec;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && out_ready) begin
                        main_d = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = StTwo;
                    end else if (out_ready) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (out_ready) begin
                        main_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        // Registered copy of the next state keeps in_ready free of combinational paths.
        in_ready_d = (state_d != StTwo);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StEmpty;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != StEmpty);
    assign out_cmd     = main_q.cmd;
    assign out_rs      = main_q.rs;
    assign out_rt      = main_q.rt;
    assign out_rd      = main_q.rd;
    assign out_shamt   = main_q.shamt;
    assign out_imm     = main_q.imm;
    assign out_jaddr   = main_q.jaddr;
    assign out_pc      = main_q.pc;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a scoreboard queue of expected entries is
// filled on accept and drained by a monitor on each output handshake.
module tb_decode_stage;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  cmd;
        logic [31:0] imm;
        logic        ill;
        logic [4:0]  cmd0;
        logic [31:0] imm0;
        logic        ill0;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        in_ready, out_valid, out_illegal;
    logic [4:0]  out_cmd, out_rs, out_rt, out_rd, out_shamt;
    logic [31:0] out_imm, out_jaddr, out_pc;

    logic        x_ready, x_valid, x_illegal;
    logic [4:0]  x_cmd, x_rs, x_rt, x_rd, x_shamt;
    logic [31:0] x_imm, x_jaddr, x_pc;

    int   n_chk  = 0;
    int   n_pass = 0;
    vec_t sb[$];
    vec_t tbl[$];
    vec_t mon_e;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .EXT_ISA(1'b1), .CMD_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
        .out_imm(out_imm), .out_jaddr(out_jaddr), .out_pc(out_pc),
        .out_illegal(out_illegal)
    );

    decode_stage #(.XLEN(32), .EXT_ISA(1'b0), .CMD_W(5)) dut_base (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(x_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(x_valid), .out_ready(out_ready), .out_cmd(x_cmd),
        .out_rs(x_rs), .out_rt(x_rt), .out_rd(x_rd), .out_shamt(x_shamt),
        .out_imm(x_imm), .out_jaddr(x_jaddr), .out_pc(x_pc),
        .out_illegal(x_illegal)
    );

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [4:0] cmd, input logic [31:0] imm,
                                input logic ill, input logic [4:0] cmd0,
                                input logic [31:0] imm0, input logic ill0);
        vec_t v;
        v.instr = instr; v.pc = pc; v.cmd = cmd; v.imm = imm; v.ill = ill;
        v.cmd0 = cmd0; v.imm0 = imm0; v.ill0 = ill0;
        return v;
    endfunction

    // Scoreboard monitor: every handshake must match the oldest outstanding entry.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_chk++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected got cmd=%0d pc=%h want no output", out_cmd, out_pc);
            end else begin
                mon_e = sb.pop_front();
                if (out_cmd !== mon_e.cmd || out_imm !== mon_e.imm || out_illegal !== mon_e.ill
                    || out_rs !== mon_e.instr[25:21] || out_rt !== mon_e.instr[20:16]
                    || out_rd !== mon_e.instr[15:11] || out_shamt !== mon_e.instr[10:6]
                    || out_jaddr !== {mon_e.pc[31:28], mon_e.instr[25:0], 2'b00}
                    || out_pc !== mon_e.pc || x_valid !== 1'b1 || x_cmd !== mon_e.cmd0
                    || x_imm !== mon_e.imm0 || x_illegal !== mon_e.ill0
                    || x_rs !== out_rs || x_rt !== out_rt || x_rd !== out_rd
                    || x_shamt !== out_shamt || x_jaddr !== out_jaddr || x_pc !== out_pc) begin
                    $display("FAIL sb_entry instr=%h got cmd=%0d imm=%h ill=%b rs=%0d rt=%0d rd=%0d sh=%0d ja=%h pc=%h base cmd=%0d imm=%h ill=%b; want cmd=%0d imm=%h ill=%b pc=%h base cmd=%0d imm=%h ill=%b",
                             mon_e.instr, out_cmd, out_imm, out_illegal, out_rs, out_rt, out_rd,
                             out_shamt, out_jaddr, out_pc, x_cmd, x_imm, x_illegal,
                             mon_e.cmd, mon_e.imm, mon_e.ill, mon_e.pc,
                             mon_e.cmd0, mon_e.imm0, mon_e.ill0);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic send(input vec_t v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instr = v.instr;
        in_pc    = v.pc;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            n_chk++;
            $display("FAIL send_timeout instr=%h in_ready=%b want 1", v.instr, in_ready);
        end else begin
            sb.push_back(v);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        #12;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        n_chk++; if (x_ready !== 1'b1) $display("FAIL reset_base_ready got %b want 1", x_ready); else n_pass++;
        n_chk++; if (out_cmd !== 5'd0) $display("FAIL reset_cmd got %0d want 0", out_cmd); else n_pass++;
        n_chk++; if (out_illegal !== 1'b0) $display("FAIL reset_illegal got %b want 0", out_illegal); else n_pass++;
        n_chk++;
        if ({out_rs, out_rt, out_rd, out_shamt} !== 20'h0 || out_imm !== 32'h0
            || out_jaddr !== 32'h0 || out_pc !== 32'h0)
            $display("FAIL reset_data got rs=%0d rt=%0d rd=%0d sh=%0d imm=%h ja=%h pc=%h want all 0",
                     out_rs, out_rt, out_rd, out_shamt, out_imm, out_jaddr, out_pc);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_decode();
        out_ready = 1'b1;
        foreach (tbl[i]) begin
            send(tbl[i]);
            n_chk++;
            if (out_valid !== 1'b1 || out_cmd !== tbl[i].cmd || x_cmd !== tbl[i].cmd0)
                $display("FAIL decode_latency instr=%h got valid=%b cmd=%0d base=%0d want 1 %0d %0d",
                         tbl[i].instr, out_valid, out_cmd, x_cmd, tbl[i].cmd, tbl[i].cmd0);
            else n_pass++;
        end
        drain();
        n_chk++;
        if (sb.size() != 0) $display("FAIL decode_drain got %0d left want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = tbl[5].instr;
        in_pc     = tbl[5].pc;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL b2b_ready0 got %b want 1", in_ready); else n_pass++;
        sb.push_back(tbl[5]);
        @(posedge clk); #1;
        n_chk++;
        if (out_valid !== 1'b1 || out_cmd !== tbl[5].cmd || in_ready !== 1'b1)
            $display("FAIL b2b_first got valid=%b cmd=%0d ready=%b want 1 %0d 1",
                     out_valid, out_cmd, in_ready, tbl[5].cmd);
        else n_pass++;
        in_instr = tbl[6].instr;
        in_pc    = tbl[6].pc;
        sb.push_back(tbl[6]);
        @(posedge clk); #1;
        n_chk++;
        if (in_ready !== 1'b0 || x_ready !== 1'b0)
            $display("FAIL b2b_full got ready=%b base=%b want 0 0", in_ready, x_ready);
        else n_pass++;
        in_instr = tbl[7].instr;
        in_pc    = tbl[7].pc;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_chk++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_cmd !== tbl[5].cmd
                || out_pc !== tbl[5].pc)
                $display("FAIL b2b_hold got ready=%b valid=%b cmd=%0d pc=%h want 0 1 %0d %h",
                         in_ready, out_valid, out_cmd, out_pc, tbl[5].cmd, tbl[5].pc);
            else n_pass++;
        end
        out_ready = 1'b1;
        send(tbl[7]);
        drain();
        n_chk++;
        if (sb.size() != 0) $display("FAIL b2b_drain got %0d left want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(tbl[0]);
        send(tbl[1]);
        n_chk++; if (in_ready !== 1'b0) $display("FAIL flush_two got ready=%b want 0", in_ready); else n_pass++;
        in_valid = 1'b1;
        in_instr = tbl[2].instr;
        in_pc    = tbl[2].pc;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_two_after got valid=%b ready=%b want 0 1", out_valid, in_ready);
        else n_pass++;
        // Flush in ONE, where the presented input would otherwise be accepted.
        send(tbl[3]);
        in_valid = 1'b1;
        in_instr = tbl[4].instr;
        in_pc    = tbl[4].pc;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL flush_one_after got valid=%b ready=%b want 0 1", out_valid, in_ready);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send(tbl[3]);
        n_chk++; if (out_valid !== 1'b1) $display("FAIL areset_pre got valid=%b want 1", out_valid); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_cmd !== 5'd0 || out_imm !== 32'h0)
            $display("FAIL areset_now got valid=%b ready=%b cmd=%0d imm=%h want 0 1 0 0",
                     out_valid, in_ready, out_cmd, out_imm);
        else n_pass++;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(tbl[4]);
        n_chk++;
        if (out_valid !== 1'b1 || out_cmd !== tbl[4].cmd || out_imm !== tbl[4].imm)
            $display("FAIL areset_after got valid=%b cmd=%0d imm=%h want 1 %0d %h",
                     out_valid, out_cmd, out_imm, tbl[4].cmd, tbl[4].imm);
        else n_pass++;
        drain();
        n_chk++;
        if (sb.size() != 0) $display("FAIL areset_drain got %0d left want 0", sb.size()); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = 32'h0;
        tbl.push_back(mk(32'h2008FFFF, 32'h00000000, 7,  32'hFFFFFFFF, 0, 7,  32'hFFFFFFFF, 0));
        tbl.push_back(mk(32'h35088000, 32'h00000100, 13, 32'h00008000, 0, 31, 32'hFFFF8000, 1));
        tbl.push_back(mk(32'h08000010, 32'h30000000, 2,  32'h00000010, 0, 2,  32'h00000010, 0));
        tbl.push_back(mk(32'h0000003F, 32'h00000104, 31, 32'h0000003F, 1, 31, 32'h0000003F, 1));
        tbl.push_back(mk(32'h3C011234, 32'h00000108, 14, 32'h12340000, 0, 31, 32'h00001234, 1));
        tbl.push_back(mk(32'h8C430004, 32'h0000010C, 0,  32'h00000004, 0, 0,  32'h00000004, 0));
        tbl.push_back(mk(32'h014B4820, 32'h00000110, 9,  32'h00004820, 0, 9,  32'h00004820, 0));
        tbl.push_back(mk(32'h00084080, 32'h00000114, 18, 32'h00004080, 0, 31, 32'h00004080, 1));
        tbl.push_back(mk(32'h3908FFFF, 32'h00000118, 6,  32'h0000FFFF, 0, 6,  32'h0000FFFF, 0));
        tbl.push_back(mk(32'h1109FFFE, 32'h0000011C, 4,  32'hFFFFFFFE, 0, 4,  32'hFFFFFFFE, 0));
        tbl.push_back(mk(32'h03E00008, 32'h00000120, 8,  32'h00000008, 0, 8,  32'h00000008, 0));
        tbl.push_back(mk(32'hFC000000, 32'h00000124, 31, 32'h00000000, 1, 31, 32'h00000000, 1));
        tbl.push_back(mk(32'h0C000100, 32'hF0000004, 3,  32'h00000100, 0, 3,  32'h00000100, 0));
        tbl.push_back(mk(32'hAC430008, 32'h00000128, 1,  32'h00000008, 0, 1,  32'h00000008, 0));
        tbl.push_back(mk(32'h15098000, 32'h0000012C, 5,  32'hFFFF8000, 0, 5,  32'hFFFF8000, 0));
        tbl.push_back(mk(32'h310800FF, 32'h00000130, 12, 32'h000000FF, 0, 31, 32'h000000FF, 1));
        tbl.push_back(mk(32'h01095027, 32'h00000134, 17, 32'h00005027, 0, 31, 32'h00005027, 1));

        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_async_reset();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
